// File: rtl/apb_sample_scheduler_pkg.sv
// Shared types for the APB sample scheduler: FSM states, request sources, error ceiling.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_sched_pkg;

    // APB master phases. IDLE is the only state with PSEL low.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Requesters, listed in descending arbitration priority.
    typedef enum logic [1:0] {
        SRC_IRQ   = 2'd0,
        SRC_QUICK = 2'd1,
        SRC_PER   = 2'd2
    } src_t;

    // Ceiling of the saturating error counter.
    localparam logic [7:0] ERR_MAX = 8'hFF;

    // Increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_sample_scheduler_fifo.sv
// Sample FIFO: first-word-fall-through storage for completed APB read samples.
// Latency: a push is visible at head_dat/empty on the cycle after the write edge.
// Backpressure: push while full is dropped unless a pop happens the same cycle; pop while empty is ignored.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   push, push_dat      write strobe and data
//   pop                 consumer pop request (ignored when empty)
//   head_dat            oldest entry (valid only when !empty)
//   count, full, empty  occupancy status
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A full FIFO can still accept a write when the head leaves the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/apb_sample_scheduler.sv
// APB read master that fetches 12-bit microphone samples for irq, host-strobe and periodic requests.
// Latency: pending request -> SETUP next cycle -> ACCESS -> sample at FIFO head the cycle after PREADY.
// Backpressure: samples queue in a FIFO drained by valid/ready; a full FIFO drops the sample and sets overflow.
//
// Ports:
//   sysclk, PRESETn                       clock, synchronous active-low reset
//   enable                                runs the period timer and admits requests
//   quick_sample, irq                     rising edge = one read request each
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA  APB master request (read only)
//   PRDATA, PREADY, PSLVERR               APB slave response
//   sample_data, sample_valid, sample_ready  FIFO output port (FWFT)
//   fifo_count, overflow, err_count, busy status
module apb_sample_scheduler
    import apb_sched_pkg::*;
#(
    parameter int          PERIOD      = 2048,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [11:0] SAMPLE_ADDR = 12'h000,
    parameter int          TIMEOUT     = 255,
    parameter int          SAMPLE_W    = 12
) (
    input  logic                          sysclk,
    input  logic                          PRESETn,
    input  logic                          enable,
    input  logic                          quick_sample,
    input  logic                          irq,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic [11:0]                   PADDR,
    output logic                          PWRITE,
    output logic [31:0]                   PWDATA,
    input  logic [31:0]                   PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    output logic [SAMPLE_W-1:0]           sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    err_count,
    output logic                          busy
);

    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic [TO_W-1:0]   acc_cnt;
    logic [TMR_W-1:0]  timer;

    logic quick_h;
    logic irq_h;
    logic quick_rise;
    logic irq_rise;
    logic timer_wrap;

    logic pend_irq;
    logic pend_quick;
    logic pend_per;

    logic grant_vld;
    src_t grant_src;

    logic fifo_push;
    logic fifo_full;
    logic fifo_empty;

    // Read-only master: address and write side are fixed.
    assign PADDR  = SAMPLE_ADDR;
    assign PWRITE = 1'b0;
    assign PWDATA = 32'd0;

    // Only the sample field of PRDATA is consumed.
    logic unused_prdata;
    assign unused_prdata = ^PRDATA[31:SAMPLE_W];

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    assign quick_rise = quick_sample & ~quick_h;
    assign irq_rise   = irq & ~irq_h;
    assign timer_wrap = enable && (timer == TMR_LAST);

    always_ff @(posedge sysclk) begin
        if (!PRESETn) begin
            quick_h <= 1'b0;
            irq_h   <= 1'b0;
        end else begin
            quick_h <= quick_sample;
            irq_h   <= irq;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!PRESETn || !enable) begin
            timer <= '0;
        end else if (timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Fixed priority irq > quick > periodic, evaluated only while idle.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_PER;
        if (state == IDLE && enable) begin
            if (pend_irq) begin
                grant_vld = 1'b1;
                grant_src = SRC_IRQ;
            end else if (pend_quick) begin
                grant_vld = 1'b1;
                grant_src = SRC_QUICK;
            end else if (pend_per) begin
                grant_vld = 1'b1;
                grant_src = SRC_PER;
            end
        end
    end

    // Grant clears only its own flag; a fresh edge in the same cycle re-arms it.
    always_ff @(posedge sysclk) begin
        if (!PRESETn || !enable) begin
            pend_irq   <= 1'b0;
            pend_quick <= 1'b0;
            pend_per   <= 1'b0;
        end else begin
            pend_irq   <= (pend_irq   & ~(grant_vld && grant_src == SRC_IRQ))   | irq_rise;
            pend_quick <= (pend_quick & ~(grant_vld && grant_src == SRC_QUICK)) | quick_rise;
            pend_per   <= (pend_per   & ~(grant_vld && grant_src == SRC_PER))   | timer_wrap;
        end
    end

    // ------------------------------------------------------------------
    // APB master FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            busy      <= 1'b0;
            acc_cnt   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state <= SETUP;
                        PSEL  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                    acc_cnt <= '0;
                end
                ACCESS: begin
                    // acc_cnt == TO_LAST marks the TIMEOUT-th ACCESS cycle.
                    if (PREADY || acc_cnt == TO_LAST) begin
                        state   <= IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        busy    <= 1'b0;
                        if (!PREADY || PSLVERR) begin
                            err_count <= sat_inc(err_count);
                        end
                    end else begin
                        acc_cnt <= acc_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample storage
    // ------------------------------------------------------------------
    assign fifo_push    = (state == ACCESS) && PREADY && !PSLVERR;
    assign sample_valid = ~fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk      (sysclk),
        .rst_n    (PRESETn),
        .push     (fifo_push),
        .push_dat (PRDATA[SAMPLE_W-1:0]),
        .pop      (sample_ready),
        .head_dat (sample_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A full FIFO only loses data when nothing leaves in the same cycle.
    always_ff @(posedge sysclk) begin
        if (!PRESETn || !enable) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !sample_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_sample_scheduler.sv
// Bench for apb_sample_scheduler: directed vectors, corner sequences and random traffic against a transaction model.
// Latency: n/a.
// Backpressure: bench plays APB slave and sample consumer.
module tb_apb_sample_scheduler;

    localparam int PERIOD  = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    logic        sysclk;
    logic        PRESETn;
    logic        enable;
    logic        quick_sample;
    logic        irq;
    logic        PSEL;
    logic        PENABLE;
    logic [11:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  err_count;
    logic        busy;

    apb_sample_scheduler #(
        .PERIOD      (PERIOD),
        .FIFO_DEPTH  (DEPTH),
        .SAMPLE_ADDR (12'h000),
        .TIMEOUT     (TIMEOUT),
        .SAMPLE_W    (12)
    ) dut (
        .sysclk       (sysclk),
        .PRESETn      (PRESETn),
        .enable       (enable),
        .quick_sample (quick_sample),
        .irq          (irq),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PADDR        (PADDR),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .err_count    (err_count),
        .busy         (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n active edges, then settle just past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: observes completed bus transfers and
    // predicts FIFO contents, overflow and the error counter.
    // ------------------------------------------------------------------
    logic [11:0] m_q [$];
    bit          m_ovf;
    int          m_err;
    int          m_acc;
    bit          m_prev_setup;
    bit          m_prev_en;
    bit          mon_on = 0;

    always @(negedge sysclk) begin
        bit push;
        bit pop;
        bit errev;
        if (mon_on) begin
            check("mon_valid", sample_valid, (m_q.size() != 0));
            check("mon_count", fifo_count, m_q.size());
            if (m_q.size() != 0) check("mon_data", sample_data, m_q[0]);
            check("mon_overflow", overflow, m_ovf);
            check("mon_err", err_count, m_err);
            check("mon_busy", busy, PSEL);
            if (PENABLE) check("mon_penable_psel", PSEL, 1);
            if (PENABLE && !m_prev_en) check("mon_setup_first", m_prev_setup, 1);
        end
        if (!PRESETn) begin
            m_q.delete();
            m_ovf = 0; m_err = 0; m_acc = 0;
            m_prev_setup = 0; m_prev_en = 0;
        end else begin
            push  = 0;
            errev = 0;
            if (PSEL && PENABLE) begin
                if (PREADY) begin
                    if (PSLVERR) errev = 1; else push = 1;
                    m_acc = 0;
                end else begin
                    m_acc++;
                    if (m_acc == TIMEOUT) begin
                        errev = 1;
                        m_acc = 0;
                    end
                end
            end else begin
                m_acc = 0;
            end
            if (errev && m_err < 255) m_err++;
            pop = (m_q.size() != 0) && sample_ready;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(PRDATA[11:0]);
                else if (enable) m_ovf = 1;
            end
            if (!enable) m_ovf = 0;
            m_prev_setup = PSEL && !PENABLE;
            m_prev_en    = PENABLE;
        end
    end

    typedef struct {
        bit          use_irq;
        logic [31:0] prdata;
        bit          slverr;
        bit          exp_valid;
        logic [11:0] exp_data;
        int          exp_err_inc;
    } vec_t;

    vec_t        vecs [6];
    logic [1:0]  pri_exp [6];
    int          setups [$];
    int          exp_err;
    int          n;

    task automatic wait_access(input string name);
        int k = 0;
        while (!PENABLE && k < 20) begin
            tick(1);
            k++;
        end
        check(name, PENABLE, 1);
    endtask

    task automatic pulse_quick();
        quick_sample = 1; tick(1); quick_sample = 0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0ABC, 1'b0, 1'b1, 12'hABC, 0};
        vecs[1] = '{1'b1, 32'hFFFF_F123, 1'b0, 1'b1, 12'h123, 0};
        vecs[2] = '{1'b0, 32'h1234_5FFF, 1'b0, 1'b1, 12'hFFF, 0};
        vecs[3] = '{1'b1, 32'hDEAD_B000, 1'b1, 1'b0, 12'h000, 1};
        vecs[4] = '{1'b0, 32'h0000_0555, 1'b1, 1'b0, 12'h000, 1};
        vecs[5] = '{1'b1, 32'h8000_0001, 1'b0, 1'b1, 12'h001, 0};
        pri_exp[0] = 2'b10; pri_exp[1] = 2'b11; pri_exp[2] = 2'b00;
        pri_exp[3] = 2'b10; pri_exp[4] = 2'b11; pri_exp[5] = 2'b00;

        PRESETn = 0; enable = 0; quick_sample = 0; irq = 0;
        PRDATA = 0; PREADY = 0; PSLVERR = 0; sample_ready = 0;
        tick(3);
        mon_on = 1;

        // Reset values
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 12'h000);
        check("rst_pwrite", PWRITE, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err_count, 0);
        check("rst_busy", busy, 0);
        PRESETn = 1;
        tick(1);

        // Single quick sample: SETUP two edges after the captured edge, data one edge after ACCESS.
        enable = 1; PREADY = 1; PRDATA = 32'h0000_0ABC;
        pulse_quick();
        check("q_idle", PSEL, 0);
        tick(1);
        check("q_setup", {PSEL, PENABLE}, 2'b10);
        tick(1);
        check("q_access", {PSEL, PENABLE}, 2'b11);
        tick(1);
        check("q_done_psel", PSEL, 0);
        check("q_valid", sample_valid, 1);
        check("q_data", sample_data, 12'hABC);
        check("q_count", fifo_count, 1);

        // Table of single transfers
        exp_err = 0;
        for (int i = 0; i < 6; i++) begin
            sample_ready = 1; tick(2); sample_ready = 0;
            enable = 0; tick(2); enable = 1;
            PRDATA = vecs[i].prdata; PSLVERR = vecs[i].slverr; PREADY = 1;
            exp_err += vecs[i].exp_err_inc;
            if (vecs[i].use_irq) irq = 1; else quick_sample = 1;
            tick(1);
            irq = 0; quick_sample = 0;
            tick(3);
            check("tbl_valid", sample_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check("tbl_data", sample_data, vecs[i].exp_data);
            check("tbl_count", fifo_count, vecs[i].exp_valid);
            check("tbl_err", err_count, exp_err);
        end
        PSLVERR = 0;

        // irq and quick together: two transfers separated by exactly one IDLE cycle.
        sample_ready = 1; tick(2); sample_ready = 0;
        enable = 0; tick(2); enable = 1;
        PRDATA = 32'h111;
        irq = 1; quick_sample = 1; tick(1); irq = 0; quick_sample = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("pri_bus", {PSEL, PENABLE}, pri_exp[i]);
            if (i == 2) PRDATA = 32'h222;
        end
        check("pri_count", fifo_count, 2);
        check("pri_head", sample_data, 12'h111);

        // Periodic timer
        sample_ready = 1;
        enable = 0; tick(2); enable = 1;
        setups.delete();
        for (int i = 1; i <= 165; i++) begin
            tick(1);
            if (PSEL && !PENABLE) setups.push_back(i);
        end
        check("per_transfers", setups.size(), 10);
        if (setups.size() > 0) check("per_first", setups[0], PERIOD + 1);
        for (int i = 1; i < setups.size(); i++) check("per_gap", setups[i] - setups[i-1], PERIOD);

        // Reset during ACCESS, with one sample stored and an irq pending.
        sample_ready = 0;
        enable = 0; tick(2); enable = 1;
        PREADY = 1; PRDATA = 32'h5A5;
        pulse_quick(); tick(3);
        check("rstx_pre_count", fifo_count, 1);
        PREADY = 0;
        pulse_quick();
        wait_access("rstx_access");
        irq = 1; tick(1);
        PRESETn = 0; tick(1);
        check("rstx_psel", PSEL, 0);
        check("rstx_penable", PENABLE, 0);
        check("rstx_busy", busy, 0);
        check("rstx_valid", sample_valid, 0);
        check("rstx_count", fifo_count, 0);
        check("rstx_err", err_count, 0);
        irq = 0; tick(1);
        PRESETn = 1; tick(4);
        check("rstx_no_pending", PSEL, 0);

        // Timeout: ACCESS held TIMEOUT cycles, then released with an error.
        pulse_quick();
        wait_access("to_access");
        n = 0;
        while (PENABLE && n < 300) begin
            n++;
            tick(1);
        end
        check("to_len", n, TIMEOUT);
        check("to_psel", PSEL, 0);
        check("to_err", err_count, 1);
        check("to_count", fifo_count, 0);
        enable = 0; tick(2); enable = 1;

        // Slave error
        PREADY = 1; PSLVERR = 1; PRDATA = 32'h999;
        pulse_quick(); tick(3);
        check("slverr_err", err_count, 2);
        check("slverr_count", fifo_count, 0);
        PSLVERR = 0;

        // Overflow: nine quick requests plus periodic ones into an undrained FIFO.
        enable = 0; tick(2); enable = 1;
        for (int i = 0; i < 9; i++) begin
            PRDATA = 32'(i + 1);
            pulse_quick(); tick(5);
        end
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_head", sample_data, 12'h001);
        enable = 0; tick(4);
        check("ovf_clear", overflow, 0);
        check("ovf_kept", fifo_count, DEPTH);
        enable = 1; PRDATA = 32'h777;
        pulse_quick(); tick(2);
        check("ovf_access", PENABLE, 1);
        sample_ready = 1; tick(1); sample_ready = 0;
        check("ovf_pp_count", fifo_count, DEPTH);
        check("ovf_pp_flag", overflow, 0);
        check("ovf_pp_head", sample_data, 12'h002);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) irq = ~irq;
            if ($urandom_range(0, 7) == 0) quick_sample = ~quick_sample;
            enable       = ($urandom_range(0, 99) < 97);
            PRESETn      = ($urandom_range(0, 999) != 0);
            PREADY       = ($urandom_range(0, 9) < 7);
            PSLVERR      = ($urandom_range(0, 9) == 0);
            PRDATA       = $urandom;
            sample_ready = $urandom_range(0, 1);
            tick(1);
        end
        PRESETn = 1; enable = 1; PREADY = 1; PSLVERR = 0; sample_ready = 1;
        irq = 0; quick_sample = 0;
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
